ex_divider: RTL and testbench



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/ex_divider.sv | 141 ++++++++++++++
 tb/tb_ex_divider.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Shared EX-stage types: divider FSM states and mul/div op encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Divide/modulo encodings of mul_div_op; 3'd0-3'd3 are the multiplies.
    localparam logic [2:0] c_MDOP_DIV  = 3'd4;
    localparam logic [2:0] c_MDOP_MOD  = 3'd5;
    localparam logic [2:0] c_MDOP_DIVU = 3'd6;
    localparam logic [2:0] c_MDOP_MODU = 3'd7;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/ex_divider.sv
// ============================================================================
// Module : ex_divider
// Radix-2 restoring signed/unsigned divider with flush and valid/ready.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_signed,
    input  logic             op_mod,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
        return (sgn && x[WIDTH-1]) ? neg(x) : x;
    endfunction

    div_state_e       state_q, state_d;
    logic             mod_q, mod_d;
    logic             dsign_q, dsign_d;
    logic             vsign_q, vsign_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             w_accept;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;

    assign in_ready  = ((state_q == DIV_IDLE) || ((state_q == DIV_DONE) && out_ready)) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (state_q == DIV_DONE);
    assign busy      = (state_q == DIV_CALC);
    assign result    = result_q;

    // Extra top bit keeps the borrow visible when the shifted remainder
    // itself spills into bit WIDTH (unsigned divisors above 2^(WIDTH-1)).
    assign w_trial  = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};
    assign w_ge     = !w_trial[WIDTH+1];
    assign w_rem_nx = w_ge ? w_trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign w_quo_nx = {quo_q[WIDTH-2:0], w_ge};

    always_comb begin
        state_d  = state_q;
        mod_d    = mod_q;
        dsign_d  = dsign_q;
        vsign_d  = vsign_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            DIV_CALC: begin
                rem_d = w_rem_nx;
                quo_d = w_quo_nx;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DIV_DONE;
                    if (mod_q) result_d = dsign_q ? neg(w_rem_nx) : w_rem_nx;
                    else       result_d = (dsign_q ^ vsign_q) ? neg(w_quo_nx) : w_quo_nx;
                end
            end
            DIV_DONE: begin
                if (out_ready) state_d = DIV_IDLE;
            end
            default: ;
        endcase

        if (w_accept) begin
            mod_d   = op_mod;
            dsign_d = op_signed && dividend[WIDTH-1];
            vsign_d = op_signed && divisor[WIDTH-1];
            if (divisor == '0) begin
                state_d  = DIV_DONE;
                cnt_d    = '0;
                result_d = op_mod ? dividend : '1;
            end else begin
                state_d = DIV_CALC;
                rem_d   = '0;
                quo_d   = abs_val(dividend, op_signed);
                dvs_d   = abs_val(divisor, op_signed);
                cnt_d   = CNT_W'(WIDTH);
            end
        end

        if (flush) state_d = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= DIV_IDLE;
            mod_q    <= 1'b0;
            dsign_q  <= 1'b0;
            vsign_q  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mod_q    <= mod_d;
            dsign_q  <= dsign_d;
            vsign_q  <= vsign_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule : ex_divider

`default_nettype wire

// File: tb/tb_ex_divider.sv
// ============================================================================
// Module : tb_ex_divider
// Directed self-checking bench for ex_divider at WIDTH=32.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_divider;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        op_signed;
    logic        op_mod;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    ex_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_signed (op_signed),
        .op_mod    (op_mod),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request, then counts cycles until out_valid (bounded).
    // n==1 is the cycle right after the accepting edge.
    task automatic run_div(input string tag, input bit s, input bit m,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int exp_lat,
                           input bit release_out);
        int n;
        op_signed = s;
        op_mod    = m;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_result"}, result, exp);
        if (release_out) tick();
    endtask

    initial begin
        int seen_valid;
        int n;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        op_signed = 1'b0;
        op_mod    = 1'b0;
        dividend  = '0;
        divisor   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        resetn = 1'b1;
        tick();

        run_div("s_m7_div_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
        run_div("s_m7_mod_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
        run_div("u_max_div_16", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, 1'b1);
        run_div("u_max_mod_16", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 33, 1'b1);
        run_div("div0_q", 1'b0, 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        run_div("div0_r", 1'b0, 1'b1, 32'h1234, 32'd0, 32'h0000_1234, 1, 1'b1);
        run_div("ovf_q", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b1);
        run_div("ovf_r", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b1);
        run_div("s_100_div_m7", 1'b1, 1'b0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 1'b1);

        // Flush in cycle T+10 of a divide.
        op_signed = 1'b0;
        op_mod    = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fl_busy_t1", 32'(busy), 32'd1);
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        #1;
        chk("fl_in_ready_gated", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_in_ready_t11", 32'(in_ready), 32'd1);
        chk("fl_busy_t11", 32'(busy), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen_valid = 1;
            tick();
        end
        chk("fl_no_out_valid", 32'(seen_valid), 32'd0);
        run_div("fl_u_100_div_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33, 1'b1);

        // Backpressure, then back-to-back handshake and accept.
        out_ready = 1'b0;
        run_div("bp_first", 1'b1, 1'b0, 32'd50, 32'd5, 32'd10, 33, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_result", result, 32'd10);
        end
        out_ready = 1'b1;
        op_signed = 1'b0;
        op_mod    = 1'b0;
        dividend  = 32'd200;
        divisor   = 32'd9;
        in_valid  = 1'b1;
        #1;
        chk("bp_in_ready_done", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_b2b_out_valid", 32'(out_valid), 32'd0);
        chk("bp_b2b_busy", 32'(busy), 32'd1);
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp_second_latency", 32'(n), 32'd33);
        chk("bp_second_result", result, 32'd22);
        tick();

        // Asynchronous reset in mid-operation.
        run_div("rst_mid_setup", 1'b0, 1'b0, 32'd77, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        dividend = 32'd77;
        divisor  = 32'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        tick();
        resetn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ex_divider

`default_nettype wire
